// File: rtl/fifo_32_to_8_pkg.sv
// fifo_32_to_8_pkg
//   Shared constants and types for the 32-to-8 bit unpacking FIFO.
//   BYTES_PER_WORD : bytes unpacked from each stored word
//   byte_idx_t     : index of the current byte inside the unpack register
//   LAST_BYTE_IDX  : index of the final byte of a word
//   RESET_BYTE     : byte value presented on DATA_OUT out of reset
package fifo_32_to_8_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t  LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);
  localparam logic [7:0] RESET_BYTE    = 8'h00;

endpackage

// File: rtl/generic_fifo.sv
// generic_fifo
//   Synchronous single-clock FIFO with show-ahead (combinational) read data.
//   Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 4).
//   Ports:
//     clk   in   clock
//     rst_n in   asynchronous active-low reset (clears pointers)
//     push  in   write din (ignored while full)
//     pop   in   drop the head entry (ignored while empty)
//     din   in   write data
//     dout  out  head entry, valid while empty is low
//     full  out  DEPTH entries stored
//     empty out  no entry stored
module generic_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fifo_32_to_8.sv
// fifo_32_to_8
//   Accepts 32-bit words into a DEPTH-word FIFO and presents them one byte at
//   a time, least significant byte first, through a one-word unpack register.
//   Total capacity is DEPTH+1 words (FIFO plus unpack register).
//   Optional feature macro: FIFO_32_TO_8_SIZE_EN adds the SIZE output.
//   Ports:
//     CLK      in   single clock
//     RST_N    in   asynchronous active-low reset
//     WRITE    in   push DATA_IN when FULL low
//     DATA_IN  in   32-bit word to unpack
//     FULL     out  word FIFO holds DEPTH words
//     READ     in   consume current byte when EMPTY low
//     EMPTY    out  no byte available
//     DATA_OUT out  current byte (show-ahead), valid while EMPTY low
//     SIZE     out  bytes available (only with FIFO_32_TO_8_SIZE_EN)
module fifo_32_to_8
  import fifo_32_to_8_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WRITE,
  input  logic [31:0] DATA_IN,
  output logic        FULL,
  input  logic        READ,
  output logic        EMPTY,
  output logic [7:0]  DATA_OUT
`ifdef FIFO_32_TO_8_SIZE_EN
  ,
  output logic [$clog2(DEPTH)+2:0] SIZE
`endif
);

  logic [31:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  logic [31:0] word_q;
  byte_idx_t   idx_q;
  logic        valid_q;

  logic        wr_acc;
  logic        rd_acc;
  logic        last_rd;
  logic        load;

  assign wr_acc  = WRITE && !fifo_full;
  assign rd_acc  = READ && valid_q;
  assign last_rd = rd_acc && (idx_q == LAST_BYTE_IDX);
  // Refill on the same edge the last byte is taken so READ held high sees no gap.
  assign load    = !fifo_empty && (!valid_q || last_rd);

  generic_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (wr_acc),
    .pop   (load),
    .din   (DATA_IN),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_q  <= {BYTES_PER_WORD{RESET_BYTE}};
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= fifo_dout;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (rd_acc) begin
      if (idx_q == LAST_BYTE_IDX) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + byte_idx_t'(1);
      end
    end
  end

  assign FULL     = fifo_full;
  assign EMPTY    = !valid_q;
  assign DATA_OUT = word_q[{idx_q, 3'b000} +: 8];

`ifdef FIFO_32_TO_8_SIZE_EN
  localparam int unsigned SW = $clog2(DEPTH) + 3;

  logic [SW-1:0] size_q;

  // Moving a word from FIFO to unpack register leaves the byte total unchanged,
  // so only accepted writes and reads adjust the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      size_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   size_q <= size_q + SW'(BYTES_PER_WORD);
        2'b11:   size_q <= size_q + SW'(BYTES_PER_WORD - 1);
        2'b01:   size_q <= size_q - SW'(1);
        default: size_q <= size_q;
      endcase
    end
  end

  assign SIZE = size_q;
`endif

endmodule

// File: tb/tb_fifo_32_to_8.sv
// tb_fifo_32_to_8
//   Directed self-checking bench for fifo_32_to_8 (DEPTH = 4): a table of
//   per-cycle vectors for the basic unpack path, then hand-written sequences
//   for full, simultaneous read/write at full, mid-stream reset and SIZE.
module tb_fifo_32_to_8;

  localparam int unsigned DEPTH = 4;

  logic        CLK     = 1'b0;
  logic        RST_N   = 1'b1;
  logic        WRITE   = 1'b0;
  logic        READ    = 1'b0;
  logic [31:0] DATA_IN = '0;
  logic        FULL;
  logic        EMPTY;
  logic [7:0]  DATA_OUT;
`ifdef FIFO_32_TO_8_SIZE_EN
  logic [$clog2(DEPTH)+2:0] SIZE;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        exp_empty;
    logic        exp_full;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t vecs [$];

  fifo_32_to_8 #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .WRITE    (WRITE),
    .DATA_IN  (DATA_IN),
    .FULL     (FULL),
    .READ     (READ),
    .EMPTY    (EMPTY),
    .DATA_OUT (DATA_OUT)
`ifdef FIFO_32_TO_8_SIZE_EN
    ,
    .SIZE     (SIZE)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic do_write(input logic [31:0] w);
    WRITE   = 1'b1;
    DATA_IN = w;
    step();
    WRITE   = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check({tag, " empty"}, 32'(EMPTY), 32'd0);
      check({tag, " byte"}, 32'(DATA_OUT), 32'(exp_q[0]));
      READ = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    READ = 1'b0;
    check({tag, " empty after drain"}, 32'(EMPTY), 32'd1);
  endtask

  // Reset asserted mid-cycle; WRITE/READ are driven during reset and must be ignored.
  task automatic apply_reset();
    #2 RST_N = 1'b0;
    #1;
    check("reset empty", 32'(EMPTY), 32'd1);
    check("reset full", 32'(FULL), 32'd0);
    check("reset data_out", 32'(DATA_OUT), 32'h00);
    WRITE   = 1'b1;
    READ    = 1'b1;
    DATA_IN = 32'hEEEE_EEEE;
    step();
    WRITE = 1'b0;
    READ  = 1'b0;
    RST_N = 1'b1;
    exp_q.delete();
    step();
    step();
    check("post-reset empty", 32'(EMPTY), 32'd1);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;

    // Basic unpack path: EMPTY latency, byte order, back-to-back words, hold.
    vecs.push_back('{1'b1, 32'h4433_2211, 1'b1, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h11});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h22});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h33});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'h44});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 32'hA3A2_A1A0, 1'b1, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 32'hB3B2_B1B0, 1'b1, 1'b0, 1'b0, 8'hA0});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hA1});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hA2});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hA3});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hB0});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hB1});
    vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 8'hB1});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hB2});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'hB3});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 8'h00});

    step();
    apply_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      WRITE   = vecs[i].wr;
      DATA_IN = vecs[i].din;
      READ    = vecs[i].rd;
      step();
      check($sformatf("vec%0d empty", i), 32'(EMPTY), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d full", i), 32'(FULL), 32'(vecs[i].exp_full));
      if (!vecs[i].exp_empty)
        check($sformatf("vec%0d data_out", i), 32'(DATA_OUT), 32'(vecs[i].exp_do));
    end
    WRITE = 1'b0;
    READ  = 1'b0;

    // DEPTH+1 words fill FIFO and unpack register; one more write is dropped.
    for (int k = 0; k <= int'(DEPTH); k++) begin
      b = 8'(4 * k);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      do_write(w);
      push_word(w);
      check($sformatf("fill%0d full", k), 32'(FULL), 32'(k == int'(DEPTH)));
    end
    do_write(32'hDEAD_BEEF);
    check("extra write full", 32'(FULL), 32'd1);
    drain("full readback");

    // At FULL, read last byte of unpack word while writing: write dropped.
    for (int k = 0; k <= int'(DEPTH); k++) begin
      b = 8'h40 + 8'(4 * k);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      do_write(w);
      push_word(w);
    end
    check("refill full", 32'(FULL), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("pre-free byte", 32'(DATA_OUT), 32'(exp_q[0]));
      READ = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    READ    = 1'b1;
    WRITE   = 1'b1;
    DATA_IN = 32'hCAFE_F00D;
    step();
    void'(exp_q.pop_front());
    READ  = 1'b0;
    WRITE = 1'b0;
    check("freed full", 32'(FULL), 32'd0);
    check("freed empty", 32'(EMPTY), 32'd0);
    check("freed next byte", 32'(DATA_OUT), 32'(exp_q[0]));
    do_write(32'h5F5E_5D5C);
    push_word(32'h5F5E_5D5C);
    check("write after free full", 32'(FULL), 32'd1);
    drain("free readback");

    // Reset mid-stream discards partial and stored words.
    do_write(32'hDDCC_BBAA);
    do_write(32'h9988_7766);
    check("mid byte0", 32'(DATA_OUT), 32'hAA);
    READ = 1'b1;
    step();
    check("mid byte1", 32'(DATA_OUT), 32'hBB);
    step();
    READ = 1'b0;
    check("mid byte2", 32'(DATA_OUT), 32'hCC);
    apply_reset();
    do_write(32'h0403_0201);
    push_word(32'h0403_0201);
    step();
    check("after reset first byte", 32'(DATA_OUT), 32'h01);
    drain("after reset");

`ifdef FIFO_32_TO_8_SIZE_EN
    apply_reset();
    check("size reset", 32'(SIZE), 32'd0);
    do_write(32'h1111_1111);
    check("size w1", 32'(SIZE), 32'd4);
    do_write(32'h2222_2222);
    check("size w2", 32'(SIZE), 32'd8);
    READ = 1'b1;
    step();
    check("size r1", 32'(SIZE), 32'd7);
    step();
    check("size r2", 32'(SIZE), 32'd6);
    step();
    check("size r3", 32'(SIZE), 32'd5);
    READ = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
